// File: rtl/iahb_lite_master.sv
// iahb_lite_master: single-beat AHB-lite initiator issuing pipelined NONSEQ transfers.
// Commands arrive on a valid/ready port, and each transfer returns one response strobe.
// Optional macro IAHB_MST_ALIGN_CHK_EN: misaligned commands are rejected locally
// and never reach the bus.
module iahb_lite_master #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                pll_core_cpuclk,
  input  logic                pad_cpu_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [2:0]          cmd_size,
  input  logic [31:0]         cmd_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   lite_yy_haddr,
  output logic [2:0]          lite_yy_hsize,
  output logic [1:0]          lite_yy_htrans,
  output logic                lite_yy_hwrite,
  output logic [31:0]         lite_yy_hwdata,
  input  logic [31:0]         mmc_lite_hrdata,
  input  logic                mmc_lite_hready,
  input  logic [1:0]          mmc_lite_hresp,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int unsigned DATA_W      = 32;
  localparam logic [1:0]  HTRANS_IDLE = 2'b00;
  localparam logic [1:0]  HTRANS_NSEQ = 2'b10;
  localparam logic [1:0]  HRESP_ERROR = 2'b01;

  // Address-phase, data-phase and response registers
  logic                ap_vld_q, ap_vld_d;
  logic                ap_write_q, ap_write_d;
  logic [ADDR_W-1:0]   ap_addr_q, ap_addr_d;
  logic [2:0]          ap_size_q, ap_size_d;
  logic [DATA_W-1:0]   ap_wdata_q, ap_wdata_d;
  logic                ap_hold_q, ap_hold_d;
  logic                dp_vld_q, dp_vld_d;
  logic                dp_write_q, dp_write_d;
  logic [DATA_W-1:0]   dp_wdata_q, dp_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic err1_c, advance_c, complete_c, accept_c, err_inc_c;
`ifdef IAHB_MST_ALIGN_CHK_EN
  logic rej_pend_q, rej_pend_d;
  logic mis_c;
`endif

  // Pipeline advance, error hold, response generation and error counting
  always_comb begin
    ap_vld_d    = ap_vld_q;
    ap_write_d  = ap_write_q;
    ap_addr_d   = ap_addr_q;
    ap_size_d   = ap_size_q;
    ap_wdata_d  = ap_wdata_q;
    ap_hold_d   = ap_hold_q;
    dp_vld_d    = dp_vld_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    err_inc_c   = 1'b0;

    // First error cycle: slave signals ERROR but is not yet ready
    err1_c     = (mmc_lite_hresp == HRESP_ERROR) && !mmc_lite_hready;
    advance_c  = mmc_lite_hready && !ap_hold_q;
    complete_c = mmc_lite_hready && dp_vld_q;
    cmd_ready  = advance_c && !err1_c;
`ifdef IAHB_MST_ALIGN_CHK_EN
    rej_pend_d = rej_pend_q;
    mis_c      = ((cmd_size == 3'b001) && cmd_addr[0]) ||
                 ((cmd_size == 3'b010) && (cmd_addr[1:0] != 2'b00)) ||
                 (cmd_size > 3'b010);
    cmd_ready  = cmd_ready && !rej_pend_q;
`endif
    accept_c = cmd_valid && cmd_ready;

    if (advance_c) begin
      dp_vld_d   = ap_vld_q;
      dp_write_d = ap_write_q;
      dp_wdata_d = ap_wdata_q;
      ap_vld_d   = 1'b0;
      if (accept_c) begin
        ap_write_d = cmd_write;
        ap_addr_d  = cmd_addr;
        ap_size_d  = cmd_size;
        ap_wdata_d = cmd_wdata;
`ifdef IAHB_MST_ALIGN_CHK_EN
        ap_vld_d   = !mis_c;
`else
        ap_vld_d   = 1'b1;
`endif
      end
    end else if (mmc_lite_hready) begin
      // Second error cycle: data phase retires, cancelled address stays for re-issue
      dp_vld_d  = 1'b0;
      ap_hold_d = 1'b0;
    end

    if (err1_c && dp_vld_q) begin
      ap_hold_d = 1'b1;
    end

    if (complete_c) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = dp_write_q ? '0 : mmc_lite_hrdata;
      rsp_err_d   = (mmc_lite_hresp == HRESP_ERROR);
      err_inc_c   = rsp_err_d;
    end

`ifdef IAHB_MST_ALIGN_CHK_EN
    // Local reject yields to a bus completion in the same cycle
    if (rej_pend_q && !complete_c) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
      err_inc_c   = 1'b1;
      rej_pend_d  = 1'b0;
    end
    if (accept_c && mis_c) begin
      if (complete_c) begin
        rej_pend_d = 1'b1;
      end else begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
        err_inc_c   = 1'b1;
      end
    end
`endif

    if (err_inc_c && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      ap_vld_q    <= 1'b0;
      ap_write_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_size_q   <= '0;
      ap_wdata_q  <= '0;
      ap_hold_q   <= 1'b0;
      dp_vld_q    <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
`ifdef IAHB_MST_ALIGN_CHK_EN
      rej_pend_q  <= 1'b0;
`endif
    end else begin
      ap_vld_q    <= ap_vld_d;
      ap_write_q  <= ap_write_d;
      ap_addr_q   <= ap_addr_d;
      ap_size_q   <= ap_size_d;
      ap_wdata_q  <= ap_wdata_d;
      ap_hold_q   <= ap_hold_d;
      dp_vld_q    <= dp_vld_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
`ifdef IAHB_MST_ALIGN_CHK_EN
      rej_pend_q  <= rej_pend_d;
`endif
    end
  end

  assign lite_yy_htrans = (ap_vld_q && !ap_hold_q) ? HTRANS_NSEQ : HTRANS_IDLE;
  assign lite_yy_haddr  = ap_addr_q;
  assign lite_yy_hsize  = ap_size_q;
  assign lite_yy_hwrite = ap_write_q;
  assign lite_yy_hwdata = dp_wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign busy           = ap_vld_q | dp_vld_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_iahb_lite_master.sv
// Directed testbench for iahb_lite_master; the bench plays the AHB slave.
// Inputs change 1ns after the rising edge, and outputs are checked before the next edge.
module tb_iahb_lite_master;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned ERRCNT_W = 8;
  localparam logic [1:0]  IDLE     = 2'b00;
  localparam logic [1:0]  NSEQ     = 2'b10;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [2:0]          cmd_size;
  logic [31:0]         cmd_wdata;
  logic                rsp_valid, rsp_err;
  logic [31:0]         rsp_rdata;
  logic [ADDR_W-1:0]   haddr;
  logic [2:0]          hsize;
  logic [1:0]          htrans;
  logic                hwrite;
  logic [31:0]         hwdata, hrdata;
  logic                hready;
  logic [1:0]          hresp;
  logic                busy;
  logic [ERRCNT_W-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_err  = 0;

  iahb_lite_master #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .lite_yy_haddr(haddr), .lite_yy_hsize(hsize), .lite_yy_htrans(htrans),
    .lite_yy_hwrite(hwrite), .lite_yy_hwdata(hwdata),
    .mmc_lite_hrdata(hrdata), .mmc_lite_hready(hready), .mmc_lite_hresp(hresp),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = 3'b010;
    cmd_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_bus(); cyc(); cyc();
    checks++;
    if ({htrans, haddr, hsize, hwrite, hwdata} !== '0) begin
      failures++; $display("FAIL reset_bus got htrans=%h haddr=%h hsize=%h hwrite=%b hwdata=%h exp all 0",
                           htrans, haddr, hsize, hwrite, hwdata);
    end
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, busy, err_cnt} !== '0) begin
      failures++; $display("FAIL reset_rsp got rsp_valid=%b rdata=%h err=%b busy=%b err_cnt=%0d exp all 0",
                           rsp_valid, rsp_rdata, rsp_err, busy, err_cnt);
    end
    rst = 1'b0; cyc();
  endtask

  task automatic test_write_read();
    idle_bus(); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF;
    #1; checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b exp=1", cmd_ready); end
    cyc();
    checks++;
    if ({htrans, haddr, hwrite} !== {NSEQ, 32'h10, 1'b1}) begin
      failures++; $display("FAIL wr_addr_phase got htrans=%h haddr=%h hwrite=%b exp 2/10/1", htrans, haddr, hwrite);
    end
    cmd_write = 1'b0; cmd_wdata = '0;
    cyc();
    checks++;
    if ({htrans, haddr, hwrite, hwdata, rsp_valid} !== {NSEQ, 32'h10, 1'b0, 32'hDEADBEEF, 1'b0}) begin
      failures++; $display("FAIL rd_addr_wr_data got htrans=%h haddr=%h hwrite=%b hwdata=%h rsp_valid=%b exp 2/10/0/deadbeef/0",
                           htrans, haddr, hwrite, hwdata, rsp_valid);
    end
    cmd_valid = 1'b0; hrdata = 32'h12345678;
    cyc();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, htrans} !== {1'b1, 1'b0, 32'h0, IDLE}) begin
      failures++; $display("FAIL wr_rsp got valid=%b err=%b rdata=%h htrans=%h exp 1/0/0/0", rsp_valid, rsp_err, rsp_rdata, htrans);
    end
    hrdata = 32'hDEADBEEF;
    cyc();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, busy} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
      failures++; $display("FAIL rd_rsp got valid=%b err=%b rdata=%h busy=%b exp 1/0/deadbeef/0", rsp_valid, rsp_err, rsp_rdata, busy);
    end
    cyc();
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_quiet got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_back_to_back_wait();
    idle_bus(); cmd_valid = 1'b1; cmd_addr = 32'h0;
    cyc();
    cmd_addr = 32'h4;
    cyc();
    hrdata = 32'hA0; cmd_addr = 32'h8;
    cyc();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, htrans, haddr} !== {1'b1, 1'b0, 32'hA0, NSEQ, 32'h8}) begin
      failures++; $display("FAIL b2b_rsp0 got valid=%b err=%b rdata=%h htrans=%h haddr=%h exp 1/0/a0/2/8",
                           rsp_valid, rsp_err, rsp_rdata, htrans, haddr);
    end
    hready = 1'b0; cmd_addr = 32'hC;
    #1; checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_wait got=%b exp=0", cmd_ready); end
    for (int w = 0; w < 2; w++) begin
      cyc();
      checks++;
      if ({rsp_valid, htrans, haddr} !== {1'b0, NSEQ, 32'h8}) begin
        failures++; $display("FAIL b2b_wait%0d got valid=%b htrans=%h haddr=%h exp 0/2/8", w, rsp_valid, htrans, haddr);
      end
    end
    hready = 1'b1; hrdata = 32'hA1;
    cyc();
    checks++;
    if ({rsp_valid, rsp_rdata, htrans, haddr} !== {1'b1, 32'hA1, NSEQ, 32'hC}) begin
      failures++; $display("FAIL b2b_rsp1 got valid=%b rdata=%h htrans=%h haddr=%h exp 1/a1/2/c", rsp_valid, rsp_rdata, htrans, haddr);
    end
    cmd_valid = 1'b0; hrdata = 32'hA2;
    cyc();
    checks++;
    if ({rsp_valid, rsp_rdata, htrans} !== {1'b1, 32'hA2, IDLE}) begin
      failures++; $display("FAIL b2b_rsp2 got valid=%b rdata=%h htrans=%h exp 1/a2/0", rsp_valid, rsp_rdata, htrans);
    end
    hrdata = 32'hA3;
    cyc();
    checks++;
    if ({rsp_valid, rsp_rdata, busy} !== {1'b1, 32'hA3, 1'b0}) begin
      failures++; $display("FAIL b2b_rsp3 got valid=%b rdata=%h busy=%b exp 1/a3/0", rsp_valid, rsp_rdata, busy);
    end
    cyc();
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_dup got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_error();
    idle_bus(); cmd_valid = 1'b1; cmd_addr = 32'h100;
    cyc();
    cmd_write = 1'b1; cmd_addr = 32'h104; cmd_wdata = 32'hCAFE0104;
    cyc();
    cmd_valid = 1'b0;
    checks++;
    if ({htrans, haddr, hwrite} !== {NSEQ, 32'h104, 1'b1}) begin
      failures++; $display("FAIL err_ap got htrans=%h haddr=%h hwrite=%b exp 2/104/1", htrans, haddr, hwrite);
    end
    hresp = 2'b01; hready = 1'b0;
    #1; checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL err_ready1 got=%b exp=0", cmd_ready); end
    cyc();
    checks++;
    if ({htrans, rsp_valid} !== {IDLE, 1'b0}) begin
      failures++; $display("FAIL err_cycle2 got htrans=%h rsp_valid=%b exp 0/0", htrans, rsp_valid);
    end
    hready = 1'b1;
    #1; checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL err_ready2 got=%b exp=0", cmd_ready); end
    cyc();
    exp_err++;
    checks++;
    if ({rsp_valid, rsp_err, err_cnt, htrans, haddr, hwrite} !== {1'b1, 1'b1, ERRCNT_W'(exp_err), NSEQ, 32'h104, 1'b1}) begin
      failures++; $display("FAIL err_rsp got valid=%b err=%b err_cnt=%0d htrans=%h haddr=%h hwrite=%b exp 1/1/%0d/2/104/1",
                           rsp_valid, rsp_err, err_cnt, htrans, haddr, hwrite, exp_err);
    end
    hresp = 2'b00;
    cyc();
    checks++;
    if ({hwdata, htrans, rsp_valid} !== {32'hCAFE0104, IDLE, 1'b0}) begin
      failures++; $display("FAIL err_reissue_dp got hwdata=%h htrans=%h valid=%b exp cafe0104/0/0", hwdata, htrans, rsp_valid);
    end
    cyc();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, err_cnt, busy} !== {1'b1, 1'b0, 32'h0, ERRCNT_W'(exp_err), 1'b0}) begin
      failures++; $display("FAIL err_wr_rsp got valid=%b err=%b rdata=%h err_cnt=%0d busy=%b exp 1/0/0/%0d/0",
                           rsp_valid, rsp_err, rsp_rdata, err_cnt, busy, exp_err);
    end
  endtask

  task automatic test_err_no_dp();
    idle_bus(); hresp = 2'b01; hready = 1'b0;
    cyc();
    hready = 1'b1;
    cyc();
    hresp = 2'b00; cmd_valid = 1'b1; cmd_addr = 32'h40;
    #1; checks++;
    if ({rsp_valid, err_cnt, cmd_ready} !== {1'b0, ERRCNT_W'(exp_err), 1'b1}) begin
      failures++; $display("FAIL err_no_dp got valid=%b err_cnt=%0d ready=%b exp 0/%0d/1", rsp_valid, err_cnt, cmd_ready, exp_err);
    end
    cmd_valid = 1'b0;
    cyc();
  endtask

  task automatic test_align();
    idle_bus(); cmd_valid = 1'b1; cmd_addr = 32'h2; cmd_size = 3'b010;
    #1; checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL align_ready got=%b exp=1", cmd_ready); end
    cyc();
    cmd_valid = 1'b0;
`ifdef IAHB_MST_ALIGN_CHK_EN
    exp_err++;
    checks++;
    if ({htrans, rsp_valid, rsp_err, rsp_rdata, err_cnt} !== {IDLE, 1'b1, 1'b1, 32'h0, ERRCNT_W'(exp_err)}) begin
      failures++; $display("FAIL align_reject got htrans=%h valid=%b err=%b rdata=%h err_cnt=%0d exp 0/1/1/0/%0d",
                           htrans, rsp_valid, rsp_err, rsp_rdata, err_cnt, exp_err);
    end
    cyc();
    checks++;
    if ({rsp_valid, busy, htrans} !== {1'b0, 1'b0, IDLE}) begin
      failures++; $display("FAIL align_after got valid=%b busy=%b htrans=%h exp 0/0/0", rsp_valid, busy, htrans);
    end
`else
    checks++;
    if ({htrans, haddr} !== {NSEQ, 32'h2}) begin
      failures++; $display("FAIL align_issue got htrans=%h haddr=%h exp 2/2", htrans, haddr);
    end
    hrdata = 32'h5A5A0002;
    cyc(); cyc();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h5A5A0002}) begin
      failures++; $display("FAIL align_rsp got valid=%b err=%b rdata=%h exp 1/0/5a5a0002", rsp_valid, rsp_err, rsp_rdata);
    end
`endif
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 256; i++) begin
      idle_bus(); cmd_valid = 1'b1; cmd_addr = ADDR_W'(i * 4);
      cyc();
      cmd_valid = 1'b0;
      cyc();
      hresp = 2'b01; hready = 1'b0;
      cyc();
      hready = 1'b1;
      cyc();
      hresp = 2'b00;
      if (exp_err < 255) exp_err++;
      checks++;
      if ({rsp_valid, rsp_err, err_cnt} !== {1'b1, 1'b1, ERRCNT_W'(exp_err)}) begin
        failures++; $display("FAIL sat_iter%0d got valid=%b err=%b err_cnt=%0d exp 1/1/%0d", i, rsp_valid, rsp_err, err_cnt, exp_err);
      end
    end
    checks++;
    if (err_cnt !== 8'hFF) begin failures++; $display("FAIL sat_final got=%0d exp=255", err_cnt); end
  endtask

  task automatic test_reset_midflight();
    idle_bus(); cmd_valid = 1'b1; cmd_addr = 32'h20;
    cyc();
    cmd_addr = 32'h24;
    cyc();
    cmd_valid = 1'b0; hready = 1'b0;
    cyc();
    checks++;
    if ({busy, htrans} !== {1'b1, NSEQ}) begin
      failures++; $display("FAIL rst_inflight got busy=%b htrans=%h exp 1/2", busy, htrans);
    end
    #2 rst = 1'b1;
    #1; checks++;
    if ({htrans, busy, rsp_valid, err_cnt} !== {IDLE, 1'b0, 1'b0, 8'h00}) begin
      failures++; $display("FAIL rst_async got htrans=%h busy=%b valid=%b err_cnt=%0d exp 0/0/0/0", htrans, busy, rsp_valid, err_cnt);
    end
    cyc();
    rst = 1'b0; hready = 1'b1; exp_err = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if ({rsp_valid, htrans, busy} !== {1'b0, IDLE, 1'b0}) begin
        failures++; $display("FAIL rst_after%0d got valid=%b htrans=%h busy=%b exp 0/0/0", k, rsp_valid, htrans, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back_wait();
    test_error();
    test_err_no_dp();
    test_align();
    test_err_saturate();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iahb_lite_master.md
Name: iahb_lite_master

Overview:
- AHB-lite initiator: takes single-beat read/write commands over a valid/ready interface and issues them as pipelined NONSEQ transfers on the lite_yy_*/mmc_lite_* bus. This is the requesting end that faces iahb_mem_ctrl.
- Address phase of transfer N+1 overlaps data phase of transfer N, so at most 2 transfers are in flight.
- Each transfer returns one response to the command source.
- Used for program loading / debug access into IRAM.

Parameters:
- ADDR_W, 32, address width of cmd_addr / lite_yy_haddr
- ERRCNT_W, 8, width of saturating error counter

Ports:
- pll_core_cpuclk  in  1  core clock, all logic on rising edge
- pad_cpu_rst  in  1  reset, asynchronous assert, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at clock edge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_size  in  3  000=byte, 001=half, 010=word
- cmd_wdata  in  32  write data, already lane-positioned
- rsp_valid  out  1  one-cycle response strobe (no backpressure)
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  transfer ended with ERROR
- lite_yy_haddr  out  ADDR_W  AHB address
- lite_yy_hsize  out  3  AHB size
- lite_yy_htrans  out  2  IDLE=00, NONSEQ=10 only
- lite_yy_hwrite  out  1  AHB direction
- lite_yy_hwdata  out  32  AHB write data (data phase)
- mmc_lite_hrdata  in  32  AHB read data
- mmc_lite_hready  in  1  transfer done / address accepted
- mmc_lite_hresp  in  2  00=OKAY, 01=ERROR
- busy  out  1  ap_vld|dp_vld
- err_cnt  out  ERRCNT_W  saturating count of ERROR responses

Behaviour:
- Reset state:
  - All registers clear. htrans=IDLE, haddr/hsize/hwrite/hwdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0, busy=0.
  - Reset mid-transfer drops all in-flight commands; no response is emitted for them.
- Address-phase register (ap: vld, write, addr, size, wdata) drives haddr/hsize/hwrite directly.
  - htrans=NONSEQ iff ap_vld & !ap_hold, else IDLE.
  - haddr/hsize/hwrite hold stable while hready=0.
- Data-phase register (dp: vld, write, wdata) drives hwdata=dp_wdata.
  - hwdata is stable for the whole data phase, including wait states.
- cmd_ready = hready & !ap_hold & !err1.
  - err1 = (hresp==01 & !hready), combinational.
- At edge with hready=1 & !ap_hold:
  - dp <= ap (dp_vld <= ap_vld).
  - ap <= accepted command, else ap_vld <= 0.
  - Back-to-back commands issue one per cycle at zero wait states.
- At edge with hready=0: ap and dp hold.
- Response timing: completion = hready=1 & dp_vld. At that edge, register rsp_valid=1, rsp_rdata=(dp_write?0:hrdata), rsp_err=(hresp==01). Response visible the cycle after completion.
- Latency:
  - Command accepted at edge T: NONSEQ on bus T..T+1, data phase T+1..T+2.
  - rsp_valid high in cycle T+2→T+3 with zero wait states.
  - Each wait state adds 1 cycle.
- ERROR handling (two-cycle response):
  - Edge in cycle 1 (hresp=01, hready=0): ap_hold <= 1, so htrans=IDLE in cycle 2 (pending address cancelled).
  - Cycle 2 (hresp=01, hready=1): dp completes with rsp_err=1; ap stays in ap (not moved to dp); ap_hold <= 0.
  - Cycle 3: the held ap command is re-issued as NONSEQ.
  - No command is lost or duplicated.
- err_cnt increments on each ERROR completion, saturates at all-ones.
- hresp=01 with dp_vld=0 is ignored (no response, no count).
- Sizes other than 000/001/010 are passed unchanged to the bus.

Optional Feature:
- IAHB_MST_ALIGN_CHK_EN
- Defined:
  - Misaligned commands (half with addr[0]=1; word with addr[1:0]!=00; size>010) are accepted but never issued on the bus.
  - The next cycle gives rsp_valid=1, rsp_err=1, rsp_rdata=0; err_cnt increments.
  - When an AHB completion and a local reject coincide, the local reject is delayed one cycle and cmd_ready is deasserted meanwhile.
- Undefined: no checking; all commands go to the bus.

Test Plan:
- Write word 0x0000_0010=0xDEADBEEF, then read same address, hready=1 throughout → bus shows NONSEQ/NONSEQ on consecutive cycles, hwdata=0xDEADBEEF in write data phase; second rsp: rdata=0xDEADBEEF, err=0.
- 4 back-to-back reads 0x0,0x4,0x8,0xC with hready=0 for 2 cycles during the 2nd data phase → haddr=0x8 held through the wait; 4 responses in order, 2-cycle gap, no duplicates.
- Read 0x100 then write 0x104, slave returns ERROR on 0x100 → cycle 2 htrans=IDLE; rsp err=1; write to 0x104 reissued in cycle 3 completes OKAY; err_cnt=1.
- Force err_cnt to 255 (ERRCNT_W=8) via 256 errored reads → err_cnt stays 255.
- Assert pad_cpu_rst during a wait state with 2 transfers in flight → htrans=IDLE immediately, busy=0, no rsp_valid after release.
- With IAHB_MST_ALIGN_CHK_EN: word read at 0x2 → no NONSEQ on bus, rsp err=1 one cycle after accept; without the macro → NONSEQ at 0x2 issued.
